// File: rtl/branch_pkg.sv
// Shared encodings for the branch sequencer: CTI types, Bicc conditions,
// FSM states and the SPARC V8 condition evaluator.
package branch_pkg;

    typedef enum logic [1:0] {
        BrBicc = 2'b00,
        BrCall = 2'b01,
        BrJmpl = 2'b10,
        BrRsvd = 2'b11
    } br_type_e;

    typedef enum logic {
        StRun  = 1'b0,
        StTrap = 1'b1
    } state_e;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } icc_t;

    localparam logic [3:0] CondBn   = 4'b0000;
    localparam logic [3:0] CondBe   = 4'b0001;
    localparam logic [3:0] CondBle  = 4'b0010;
    localparam logic [3:0] CondBl   = 4'b0011;
    localparam logic [3:0] CondBleu = 4'b0100;
    localparam logic [3:0] CondBcs  = 4'b0101;
    localparam logic [3:0] CondBneg = 4'b0110;
    localparam logic [3:0] CondBvs  = 4'b0111;
    localparam logic [3:0] CondBa   = 4'b1000;

    // Codes 1xxx are the complements of 0xxx, so only the low half is decoded.
    function automatic logic cond_eval(input logic [3:0] cond, input icc_t icc);
        logic base;
        case (cond[2:0])
            3'b000:  base = 1'b0;
            3'b001:  base = icc.z;
            3'b010:  base = icc.z | (icc.n ^ icc.v);
            3'b011:  base = icc.n ^ icc.v;
            3'b100:  base = icc.c | icc.z;
            3'b101:  base = icc.c;
            3'b110:  base = icc.n;
            default: base = icc.v;
        endcase
        return cond[3] ? ~base : base;
    endfunction

endpackage

// File: rtl/branch_seq_if.sv
// Fetch-advance / CTI request bus between the pipeline and the branch sequencer.
interface branch_seq_if;

    logic        adv;
    logic        br_valid;
    logic [1:0]  br_type;
    logic [3:0]  cond;
    logic        annul;
    logic [29:0] disp;
    logic [3:0]  icc;
    logic [31:0] jmpl_tgt;
    logic        trap_ack;

    logic [31:0] pc;
    logic [31:0] npc;
    logic        fetch_valid;
    logic        squash;
    logic        taken;
    logic        trap;

    modport master (
        output adv, br_valid, br_type, cond, annul, disp, icc, jmpl_tgt, trap_ack,
        input  pc, npc, fetch_valid, squash, taken, trap
    );

    modport slave (
        input  adv, br_valid, br_type, cond, annul, disp, icc, jmpl_tgt, trap_ack,
        output pc, npc, fetch_valid, squash, taken, trap
    );

endinterface

// File: rtl/br_target_calc.sv
// Combinational PC-relative target: Bicc uses a sign-extended disp22,
// CALL uses the full disp30; other types return pc unchanged.
module br_target_calc
    import branch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [29:0] disp,
    input  br_type_e    br_type,
    output logic [31:0] target
);

    logic [31:0] offset;

    // Select the word-scaled displacement for the CTI type.
    always_comb begin
        offset = '0;
        case (br_type)
            BrBicc:  offset = {{8{disp[21]}}, disp[21:0], 2'b00};
            BrCall:  offset = {disp, 2'b00};
            default: offset = '0;
        endcase
    end

    // Addition wraps modulo 2^32 by construction.
    assign target = pc + offset;

endmodule

// File: rtl/branch_seq.sv
// SPARC-style delayed-branch PC/nPC sequencer with annul handling and a
// misaligned-JMPL trap state.
module branch_seq
    import branch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    branch_seq_if.slave  bus
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] npc_q, npc_d;
    logic        fv_q, fv_d;
    logic        squash_q, squash_d;
    logic        taken_q, taken_d;

    br_type_e    br_kind;
    logic [31:0] target;
    logic [31:0] npc_inc;
    logic        is_cti;
    logic        bicc_tk;
    logic        uncond;

    assign br_kind = br_type_e'(bus.br_type);
    assign npc_inc = npc_q + 32'd4;
    // An annulled delay slot never executes, so a CTI sitting in it is ignored.
    assign is_cti  = bus.br_valid && !squash_q && (br_kind != BrRsvd);
    assign bicc_tk = cond_eval(bus.cond, icc_t'(bus.icc));
    assign uncond  = (bus.cond == CondBa) || (bus.cond == CondBn);

    br_target_calc u_target (
        .pc      (pc_q),
        .disp    (bus.disp),
        .br_type (br_kind),
        .target  (target)
    );

    // Next-state: sequential advance, CTI redirection, annul and trap entry/exit.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        npc_d    = npc_q;
        squash_d = squash_q;
        taken_d  = 1'b0;
        unique case (state_q)
            StRun: begin
                if (bus.adv) begin
                    pc_d     = npc_q;
                    npc_d    = npc_inc;
                    squash_d = 1'b0;
                    if (is_cti) begin
                        case (br_kind)
                            BrBicc: begin
                                if (bicc_tk) begin
                                    npc_d = target;
                                end
                                taken_d  = bicc_tk;
                                squash_d = bus.annul && (uncond || !bicc_tk);
                            end
                            BrCall: begin
                                npc_d   = target;
                                taken_d = 1'b1;
                            end
                            BrJmpl: begin
                                if (bus.jmpl_tgt[1:0] != 2'b00) begin
                                    pc_d     = pc_q;
                                    npc_d    = npc_q;
                                    squash_d = squash_q;
                                    state_d  = StTrap;
                                end else begin
                                    npc_d   = bus.jmpl_tgt;
                                    taken_d = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            StTrap: begin
                if (bus.trap_ack) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
        fv_d = (state_d == StRun);
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StRun;
            pc_q     <= RESET_PC;
            npc_q    <= RESET_PC + 32'd4;
            fv_q     <= 1'b0;
            squash_q <= 1'b0;
            taken_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            npc_q    <= npc_d;
            fv_q     <= fv_d;
            squash_q <= squash_d;
            taken_q  <= taken_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.npc         = npc_q;
    assign bus.fetch_valid = fv_q;
    assign bus.squash      = squash_q;
    assign bus.taken       = taken_q;
    assign bus.trap        = (state_q == StTrap);

endmodule

// File: tb/tb_branch_seq.sv
// Scoreboard bench for branch_seq: directed scenarios plus random stimulus
// against a behavioural PC/nPC model.
module tb_branch_seq;

    localparam logic [31:0] ResetPc = 32'h0000_0100;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic        fv;
        logic        squash;
        logic        taken;
        logic        trap;
        int unsigned due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc = 0;
    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    exp_t        sb[$];

    // Reference model state.
    logic [31:0] m_pc, m_npc;
    bit          m_fv, m_sq, m_tk, m_trap;

    branch_seq_if bus_if ();

    branch_seq #(.RESET_PC(ResetPc)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    endtask

    function automatic bit cond_holds(input logic [3:0] cnd, input logic [3:0] icc);
        bit n, z, v, c;
        {n, z, v, c} = icc;
        case (cnd)
            4'd0:  return 0;
            4'd1:  return z;
            4'd2:  return z || (n != v);
            4'd3:  return n != v;
            4'd4:  return c || z;
            4'd5:  return c;
            4'd6:  return n;
            4'd7:  return v;
            4'd8:  return 1;
            4'd9:  return !z;
            4'd10: return !(z || (n != v));
            4'd11: return n == v;
            4'd12: return !(c || z);
            4'd13: return !c;
            4'd14: return !n;
            default: return !v;
        endcase
    endfunction

    // Drive one cycle of inputs, advance the model, queue the expected outputs.
    task automatic step(input bit adv, input bit brv, input logic [1:0] bt,
                        input logic [3:0] cnd, input bit an, input logic [29:0] dsp,
                        input logic [3:0] icc, input logic [31:0] jt, input bit ack);
        longint      off;
        logic [31:0] nn;
        bit          tk, new_sq;
        exp_t        e;
        bus_if.adv = adv;      bus_if.br_valid = brv; bus_if.br_type  = bt;
        bus_if.cond = cnd;     bus_if.annul    = an;  bus_if.disp     = dsp;
        bus_if.icc = icc;      bus_if.jmpl_tgt = jt;  bus_if.trap_ack = ack;
        if (m_trap) begin
            m_tk = 0;
            if (ack) m_trap = 0;
        end else if (!adv) begin
            m_tk = 0;
        end else begin
            tk = 0;
            new_sq = 0;
            nn = m_npc + 32'd4;
            if (brv && !m_sq && bt != 2'd3) begin
                if (bt == 2'd0) begin
                    off = longint'(dsp[21:0]);
                    if (off >= 'h20_0000) off -= 'h40_0000;
                    tk = cond_holds(cnd, icc);
                    if (tk) nn = m_pc + 32'(off * 4);
                    new_sq = an && (cnd == 4'd0 || cnd == 4'd8 || !tk);
                end else if (bt == 2'd1) begin
                    tk = 1;
                    nn = m_pc + 32'(longint'(dsp) * 4);
                end else if (jt % 4 != 0) begin
                    m_trap = 1;
                end else begin
                    tk = 1;
                    nn = jt;
                end
            end
            if (!m_trap) begin
                m_pc  = m_npc;
                m_npc = nn;
                m_sq  = new_sq;
            end
            m_tk = tk;
        end
        m_fv = !m_trap;
        e.pc = m_pc; e.npc = m_npc; e.fv = m_fv; e.squash = m_sq;
        e.taken = m_tk; e.trap = m_trap; e.due = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic adv1();
        step(1, 0, 2'd0, 4'd0, 0, 30'd0, 4'd0, 32'd0, 0);
    endtask

    task automatic jmpl(input logic [31:0] jt);
        step(1, 1, 2'd2, 4'd0, 0, 30'd0, 4'd0, jt, 0);
    endtask

    // Assert reset mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_pc", bus_if.pc, ResetPc);
        chk("rst_npc", bus_if.npc, ResetPc + 32'd4);
        chk("rst_fv", 32'(bus_if.fetch_valid), 32'd0);
        chk("rst_trap", 32'(bus_if.trap), 32'd0);
        chk("rst_squash", 32'(bus_if.squash), 32'd0);
        chk("rst_taken", 32'(bus_if.taken), 32'd0);
        sb.delete();
        m_pc = ResetPc; m_npc = ResetPc + 32'd4;
        m_fv = 0; m_sq = 0; m_tk = 0; m_trap = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Pop and compare every expectation that falls due on this cycle.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                chk("sb_due", e.due, cyc);
                chk("sb_pc", bus_if.pc, e.pc);
                chk("sb_npc", bus_if.npc, e.npc);
                chk("sb_fv", 32'(bus_if.fetch_valid), 32'(e.fv));
                chk("sb_squash", 32'(bus_if.squash), 32'(e.squash));
                chk("sb_taken", 32'(bus_if.taken), 32'(e.taken));
                chk("sb_trap", 32'(bus_if.trap), 32'(e.trap));
            end
        end
    endtask

    initial begin
        bit          r_adv, r_brv, r_an, r_ack;
        logic [1:0]  r_bt;
        logic [3:0]  r_cnd, r_icc;
        logic [29:0] r_dsp;
        logic [31:0] r_jt;
        bus_if.adv = 0; bus_if.br_valid = 0; bus_if.br_type = 0; bus_if.cond = 0;
        bus_if.annul = 0; bus_if.disp = 0; bus_if.icc = 0; bus_if.jmpl_tgt = 0;
        bus_if.trap_ack = 0;
        fork
            monitor();
        join_none
        @(posedge clk);
        #1;
        do_reset();

        // Sequential fetch after reset.
        adv1(); chk("seq_104", bus_if.pc, 32'h104);
        chk("seq_fv", 32'(bus_if.fetch_valid), 32'd1);
        adv1(); chk("seq_108", bus_if.pc, 32'h108);
        adv1(); chk("seq_10c", bus_if.pc, 32'h10C);

        // BE taken backwards from 0x200.
        jmpl(32'h200); adv1(); chk("at_200", bus_if.pc, 32'h200);
        step(1, 1, 2'd0, 4'b0001, 0, 30'h3FFFFE, 4'b0100, 32'd0, 0);
        chk("be_pc", bus_if.pc, 32'h204); chk("be_npc", bus_if.npc, 32'h1F8);
        chk("be_taken", 32'(bus_if.taken), 32'd1);
        chk("be_squash", 32'(bus_if.squash), 32'd0);
        adv1(); chk("be_tgt", bus_if.pc, 32'h1F8);

        // BNE,a not taken squashes the slot and holds it across adv=0.
        jmpl(32'h300); adv1();
        step(1, 1, 2'd0, 4'b1001, 1, 30'h10, 4'b0100, 32'd0, 0);
        chk("bne_pc", bus_if.pc, 32'h304); chk("bne_sq", 32'(bus_if.squash), 32'd1);
        step(0, 0, 2'd0, 4'd0, 0, 30'd0, 4'd0, 32'd0, 0);
        chk("hold_sq", 32'(bus_if.squash), 32'd1); chk("hold_pc", bus_if.pc, 32'h304);
        adv1(); chk("bne_next", bus_if.pc, 32'h308);
        chk("bne_unsq", 32'(bus_if.squash), 32'd0);
        // BA,a: slot squashed, target still followed.
        step(1, 1, 2'd0, 4'b1000, 1, 30'h10, 4'd0, 32'd0, 0);
        chk("ba_sq", 32'(bus_if.squash), 32'd1); chk("ba_npc", bus_if.npc, 32'h348);
        adv1(); chk("ba_tgt", bus_if.pc, 32'h348);

        // CALL with maximal disp from 0 wraps to 0xFFFFFFFC, then pc wraps to 0.
        jmpl(32'h0); adv1();
        step(1, 1, 2'd1, 4'd0, 0, 30'h3FFF_FFFF, 4'd0, 32'd0, 0);
        chk("call_npc", bus_if.npc, 32'hFFFF_FFFC);
        adv1(); chk("call_pc", bus_if.pc, 32'hFFFF_FFFC);
        adv1(); chk("wrap_pc", bus_if.pc, 32'h0);

        // DCTI couple.
        jmpl(32'h400); adv1(); chk("dcti_400", bus_if.pc, 32'h400);
        step(1, 1, 2'd0, 4'b1000, 0, 30'h100, 4'd0, 32'd0, 0);
        chk("dcti_404", bus_if.pc, 32'h404);
        step(1, 1, 2'd0, 4'b1000, 0, 30'h1FF, 4'd0, 32'd0, 0);
        chk("dcti_800", bus_if.pc, 32'h800);
        adv1(); chk("dcti_c00", bus_if.pc, 32'hC00);

        // Misaligned JMPL trap, adv ignored, acknowledge, then reset mid-trap.
        jmpl(32'h1002);
        chk("trap_on", 32'(bus_if.trap), 32'd1);
        chk("trap_fv", 32'(bus_if.fetch_valid), 32'd0);
        adv1(); chk("trap_hold", bus_if.pc, 32'hC00);
        step(1, 0, 2'd0, 4'd0, 0, 30'd0, 4'd0, 32'd0, 1);
        chk("ack_trap", 32'(bus_if.trap), 32'd0);
        chk("ack_npc", bus_if.npc, 32'hC04);
        jmpl(32'h1002);
        do_reset();

        // Random stimulus against the model.
        for (int i = 0; i < 400; i++) begin
            r_adv = $urandom_range(0, 3) != 0;
            r_brv = $urandom_range(0, 9) < 4 && !m_sq;
            r_bt  = 2'($urandom_range(0, 3));
            r_cnd = 4'($urandom);
            r_an  = 1'($urandom);
            r_dsp = 30'($urandom);
            r_icc = 4'($urandom);
            r_jt  = $urandom;
            if ($urandom_range(0, 3) != 0) r_jt[1:0] = 2'b00;
            r_ack = $urandom_range(0, 2) == 0;
            step(r_adv, r_brv, r_bt, r_cnd, r_an, r_dsp, r_icc, r_jt, r_ack);
        end

        @(negedge clk);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/branch_seq.md
BRANCH_SEQ -- requirements
Module: branch_seq

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded at reset; nPC SHALL load RESET_PC+4.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 adv  in  1  the pipeline accepts the current PC this cycle (advance handshake).
REQ-005 br_valid  in  1  the instruction at the current PC is a control-transfer instruction (CTI); sampled only when adv=1.
REQ-006 br_type  in  2  00 Bicc disp22, 01 CALL disp30, 10 JMPL register target, 11 reserved (treated as not-a-CTI).
REQ-007 cond  in  4  SPARC Bicc condition field.
REQ-008 annul  in  1  Bicc a-bit.
REQ-009 disp  in  30  displacement; Bicc uses bits [21:0], CALL uses all 30 bits.
REQ-010 icc  in  4  {N,Z,V,C} condition codes, valid when br_valid=1.
REQ-011 jmpl_tgt  in  32  computed JMPL target address.
REQ-012 trap_ack  in  1  trap handler acknowledge.
REQ-013 pc  out  32  address of the current fetch.
REQ-014 npc  out  32  next PC.
REQ-015 fetch_valid  out  1  pc holds a valid fetch address.
REQ-016 squash  out  1  the instruction at pc is annulled (delay slot killed).
REQ-017 taken  out  1  one-cycle pulse: the CTI accepted on the previous adv transferred control.
REQ-018 trap  out  1  misaligned-target trap pending.

Function
REQ-019 States SHALL be RUN, TRAP.
REQ-020 In RUN with adv=1 and no CTI, the block SHALL load pc<=npc and npc<=npc+4.
REQ-021 A Bicc target SHALL be pc + (sign-extend(disp[21:0])<<2), computed modulo 2^32.
REQ-022 A CALL target SHALL be pc + (disp<<2), computed modulo 2^32; CALL SHALL always be taken.
REQ-023 Bicc conditions SHALL follow the SPARC V8 table: BN=0000, BE=0001 Z, BLE=0010 Z|(N^V), BL=0011 N^V, BLEU=0100 C|Z, BCS=0101 C, BNEG=0110 N, BVS=0111 V; codes 1xxx SHALL be the complements, with BA=1000.
REQ-024 A taken CTI SHALL load pc<=npc and npc<=target, so the delay slot always executes unless squashed.
REQ-025 An untaken Bicc SHALL sequence as in REQ-020.
REQ-026 squash SHALL assert for the delay slot in two cases: (a) annul=1 and cond is BA or BN; (b) annul=1 and a conditional Bicc is not taken.
REQ-027 squash SHALL hold until the next adv.
REQ-028 A JMPL SHALL load pc<=npc and npc<=jmpl_tgt.
REQ-029 If jmpl_tgt[1:0]!=0, the block SHALL instead hold pc/npc, enter TRAP, and assert trap with fetch_valid=0.
REQ-030 In TRAP, the block SHALL ignore adv; on trap_ack it SHALL return to RUN with pc/npc unchanged.
REQ-031 With adv=0, all state SHALL hold; squash and trap SHALL stay stable.
REQ-032 A CTI in the delay slot of a taken CTI SHALL be processed normally (DCTI couple).
REQ-033 pc=32'hFFFF_FFFC SHALL wrap to 0 when incremented.
REQ-034 Latency: pc/npc and taken SHALL update one cycle after the adv edge; the design SHALL contain no combinational path from inputs to pc/npc.
REQ-035 br_type 11 SHALL behave as no CTI.

Reset
REQ-036 On rst_n=0, asynchronously: pc=RESET_PC, npc=RESET_PC+4, state=RUN, squash=0, taken=0, trap=0.
REQ-037 fetch_valid SHALL be 0 during reset and SHALL assert on the first clk edge after deassertion.
REQ-038 Reset in TRAP SHALL clear trap immediately.

Structure
REQ-039 Condition encodings, br_type codes and state encoding SHALL reside in the shared package branch_pkg.
REQ-040 Target computation SHALL be a sub-module br_target_calc (combinational: pc, disp, br_type -> target).

Verification
REQ-041 Reset with RESET_PC=0x100, then 3 advances -> pc sequence 0x100, 0x104, 0x108, 0x10C; fetch_valid=1 from the first edge.
REQ-042 BE with Z=1, disp22=0x3FFFFE at pc=0x200 -> next pc=0x204, then 0x1F8; taken=1; squash=0.
REQ-043 BNE a=1 with Z=1 at pc=0x300 -> squash=1 for pc=0x304, then pc=0x308; BA a=1 -> delay slot squashed and target followed.
REQ-044 CALL disp=0x3FFFFFFF at pc=0x0 -> target 0xFFFFFFFC.
REQ-045 JMPL jmpl_tgt=0x1002 -> trap=1, fetch_valid=0, adv ignored; trap_ack -> RUN with pc/npc unchanged; reset mid-TRAP -> trap=0 immediately.
REQ-046 DCTI couple: taken BA at 0x400 to 0x800 with BA to 0xC00 in the delay slot -> pc sequence 0x400, 0x404, 0x800, 0xC00.
